gio_wr_arbiter: RTL
===================

# gio_wr_arbiter

Round-robin write arbiter that shares the memory-mapped general-purpose output port bus among up to four bus masters (CPU store path, DMA, debug). Each requester presents a write with a valid/ready handshake. The arbiter serialises accepted writes into single-cycle `wen` pulses with registered `addr`/`wdata`, which drive every output-port instance on the bus. A programmable idle gap after each write lets slow downstream consumers settle.

## Interface
- `NREQ`, 2, number of requesters, legal 2..4
- `WIDTH`, 8, data width of the output-port bus
- `GAP`, 0, idle cycles inserted after each issued write, legal 0..15
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  requester i has a pending write
- `req_addr`  in  32*NREQ  requester i address in bits [32*i+31:32*i]
- `req_wdata`  in  WIDTH*NREQ  requester i data in bits [WIDTH*i+WIDTH-1:WIDTH*i]
- `req_ready`  out  NREQ  one-hot; write of requester i is accepted this cycle
- `addr`  out  32  registered address to the output-port bus
- `wdata`  out  WIDTH  registered data to the output-port bus
- `wen`  out  1  single-cycle write strobe to the output-port bus
- `grant_id`  out  2  index of the requester that owns the current/last write
- `busy`  out  1  high in ISSUE and GAP states

## Operation
- States: IDLE, ISSUE, GAP.
- IDLE:
  - If any `req_valid` is set, select the winner by round-robin. Search starts at `last_grant+1` mod `NREQ`; the first set valid wins.
  - `req_ready[winner]` is driven combinationally high in the same cycle.
  - On the edge, latch the winner's `addr`/`wdata`, set `grant_id` and `last_grant` to the winner, assert `wen`, and go to ISSUE.
  - With no valid, stay in IDLE.
- ISSUE: `wen`=1 for exactly this cycle. Next state is GAP if `GAP`>0 (counter loaded with `GAP`-1), else IDLE.
- GAP: `wen`=0. Counter decrements each cycle; go to IDLE when the counter is 0.
- `req_ready` is all-zero outside IDLE and in IDLE with no valid. It is never more than one-hot.
- Transfer happens when `req_valid[i]` && `req_ready[i]` are both high. Requesters hold `req_valid`, addr and data stable until the transfer. The arbiter never samples a requester's addr/data except in its transfer cycle.
- `req_valid` deasserting before transfer is legal: the request is withdrawn and not issued.
- `addr`/`wdata` hold their last values after ISSUE. Only `wen` qualifies them.
- `NREQ`<4: `grant_id` upper values are unused; `req_*` widths scale with `NREQ`.

## Timing
- Reset values: `wen`=0, `addr`=0, `wdata`=0, `req_ready`=0, `grant_id`=0, `busy`=0, state IDLE, `last_grant`=`NREQ`-1 (so requester 0 wins first), gap counter 0.
- Latency: request accepted in cycle t gives `wen`=1 in cycle t+1.
- Throughput: one write per 2+`GAP` cycles under continuous requests.
- Simultaneous requests: only one is granted per IDLE cycle. Losers keep `req_valid` high and are served in round-robin order. With all requesters continuously valid, each is granted once every `NREQ` writes (no starvation).
- Reset has priority over every state:
  - Reset asserted during ISSUE forces `wen`=0 on the next edge. The accepted write may not reach the bus; its handshake is already complete and it is not retried.
  - Reset during GAP returns to IDLE immediately.
- No combinational path from `req_addr`/`req_wdata` to outputs. The only combinational path is `req_valid` to `req_ready`.

## Test plan
- Reset then single request: requester 1 valid with addr=0x10, wdata=0xA5. Required: `req_ready`=0b0010 in the same cycle; next cycle `wen`=1, `addr`=0x10, `wdata`=0xA5, `grant_id`=1; then `wen`=0.
- All four requesters valid continuously, `GAP`=0: grants follow 0,1,2,3,0,1… with `wen` pulses every 2 cycles and exactly one `req_ready` bit per acceptance.
- `GAP`=3: back-to-back requests from requester 0 give `wen` pulses 5 cycles apart, with `busy` high for 4 cycles after each acceptance.
- Withdrawal: requester 2 raises `req_valid` during GAP, then drops it before IDLE. Required: no grant to 2 and no `wen`; the next request from requester 3 is granted normally.
- Reset mid-operation: assert `reset` in the ISSUE cycle. Required: next cycle `wen`=0, `addr`=0, `wdata`=0, `busy`=0. The subsequent first grant goes to requester 0 when 0 and 3 are both valid.
- Stability: hold requester 0 valid while changing its `req_wdata` in GAP cycles. Required: the bus shows only the value present in the transfer cycle.

Source files
------------

// File: rtl/gio_wr_arbiter.sv
// gio_wr_arbiter: round-robin arbiter serialising requester writes onto the output-port bus
module gio_wr_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [32*NREQ-1:0]    req_addr,
  input  logic [WIDTH*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [31:0]           addr,
  output logic [WIDTH-1:0]      wdata,
  output logic                  wen,
  output logic [1:0]            grant_id,
  output logic                  busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
  localparam logic [3:0] GAP_LOAD = 4'(GAP > 0 ? GAP - 1 : 0);
  localparam logic [1:0] LAST_RST = 2'(NREQ - 1);
  state_t           state, state_nx;
  logic [1:0]       last_grant, win, idx;
  logic             found, accept;
  logic [3:0]       cnt, valid4;
  logic [31:0]      a_arr [4];
  logic [WIDTH-1:0] d_arr [4];
  for (genvar g = 0; g < 4; g++) begin : g_unpack
    if (g < NREQ) begin : g_used
      assign a_arr[g] = req_addr[32*g +: 32];
      assign d_arr[g] = req_wdata[WIDTH*g +: WIDTH];
    end else begin : g_unused
      assign a_arr[g] = '0;
      assign d_arr[g] = '0;
    end
  end
  assign valid4 = 4'(req_valid);
  // first valid requester after the last winner, wrapping at NREQ
  always_comb begin
    win   = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = 2'((int'(last_grant) + k) % NREQ);
      if (!found && valid4[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  assign accept    = state == S_IDLE && found && !reset;
  assign req_ready = accept ? NREQ'(1) << win : '0;
  assign wen       = state == S_ISSUE;
  assign busy      = state != S_IDLE;
  always_comb begin
    state_nx = state == S_IDLE  ? (found ? S_ISSUE : S_IDLE) :
               state == S_ISSUE ? (GAP > 0 ? S_GAP : S_IDLE) :
               (cnt == 4'd0 ? S_IDLE : S_GAP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= LAST_RST;
      grant_id   <= '0;
      addr       <= '0;
      wdata      <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant <= win;
        grant_id   <= win;
        addr       <= a_arr[win];
        wdata      <= d_arr[win];
      end
      if (state == S_ISSUE) cnt <= GAP_LOAD;
      else if (state == S_GAP && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end
endmodule
